// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch and load/store) onto a byte-wide single-port RAM.
// Transfers are moved one byte per cycle; the MEM port has fixed priority over IF.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_data_o,
    input  logic        flush_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [1:0]  mem_len_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_ack_o,
    output logic [31:0] mem_rdata_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_wr_o,
    output logic [7:0]  ram_dout_o,
    input  logic [7:0]  ram_din_i,
    output logic        busy_o
);
    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  n_bytes;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf;
    logic        owner_mem;

    logic [2:0]  mem_n;
    logic [1:0]  cap_idx;
    logic [2:0]  rd_off;

    always_comb begin
        case (mem_len_i)
            2'b00:   mem_n = 3'd1;
            2'b01:   mem_n = 3'd2;
            default: mem_n = 3'd4;
        endcase
    end

    // RAM read data lags its address by one cycle, so the byte arriving at cnt lands in slot cnt-1.
    assign cap_idx = 2'(cnt - 3'd1);
    assign rd_off  = (cnt == n_bytes) ? (n_bytes - 3'd1) : cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            n_bytes   <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            rbuf      <= 32'd0;
            owner_mem <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req_i) begin
                        state     <= mem_we_i ? MEM_WR : MEM_RD;
                        owner_mem <= 1'b1;
                        addr_q    <= mem_addr_i;
                        wdata_q   <= mem_wdata_i;
                        n_bytes   <= mem_n;
                        cnt       <= 3'd0;
                        rbuf      <= 32'd0;
                    end else if (if_req_i && !flush_i) begin
                        state     <= IF_RD;
                        owner_mem <= 1'b0;
                        addr_q    <= if_addr_i;
                        wdata_q   <= 32'd0;
                        n_bytes   <= 3'd4;
                        cnt       <= 3'd0;
                        rbuf      <= 32'd0;
                    end
                end
                IF_RD, MEM_RD: begin
                    if (state == IF_RD && flush_i) begin
                        state <= IDLE;
                    end else begin
                        if (cnt != 3'd0) begin
                            rbuf[{cap_idx, 3'b000} +: 8] <= ram_din_i;
                        end
                        if (cnt == n_bytes) begin
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                MEM_WR: begin
                    if (cnt + 3'd1 == n_bytes) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ram_addr_o = 32'd0;
        ram_wr_o   = 1'b0;
        ram_dout_o = 8'd0;
        case (state)
            IF_RD, MEM_RD: ram_addr_o = addr_q + 32'(rd_off);
            MEM_WR: begin
                ram_wr_o   = 1'b1;
                ram_addr_o = addr_q + 32'(cnt);
                ram_dout_o = wdata_q[{cnt[1:0], 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    // A flush arriving in the DONE cycle must still kill the fetch ack, so the IF ack looks at flush_i directly.
    assign busy_o      = (state != IDLE);
    assign if_ack_o    = (state == DONE) && !owner_mem && !flush_i;
    assign mem_ack_o   = (state == DONE) && owner_mem;
    assign if_data_o   = if_ack_o ? rbuf : 32'd0;
    assign mem_rdata_o = mem_ack_o ? rbuf : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a byte RAM environment plus a transaction-level model
// that predicts the per-cycle RAM/ack trace and the returned data.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ack_o;
    logic [31:0] if_data_o;
    logic        flush_i;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [1:0]  mem_len_i;
    logic [31:0] mem_wdata_i;
    logic        mem_ack_o;
    logic [31:0] mem_rdata_o;
    logic [31:0] ram_addr_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;
    logic        busy_o;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_data_o(if_data_o),
        .flush_i(flush_i),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_len_i(mem_len_i),
        .mem_wdata_i(mem_wdata_i), .mem_ack_o(mem_ack_o), .mem_rdata_o(mem_rdata_o),
        .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i),
        .busy_o(busy_o)
    );

    // Byte RAM seen by the DUT (low 16 address bits) and the model's own copy of memory.
    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (ram_wr_o) ram[ram_addr_o[15:0]] <= ram_dout_o;
        ram_din_i <= ram[ram_addr_o[15:0]];
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [43:0] exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + (i >> 8) * 11 + 8'h5a);
    endfunction

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    // Trace entry: {mem_ack, if_ack, busy, wr, dout, addr}
    function automatic logic [43:0] ent(input bit ma, input bit ia, input bit b, input bit w,
                                        input logic [7:0] d, input logic [31:0] a);
        return {ma, ia, b, w, d, a};
    endfunction

    function automatic logic [43:0] obs();
        return {mem_ack_o, if_ack_o, busy_o, ram_wr_o, ram_dout_o, ram_addr_o};
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
        logic [31:0] v;
        logic [31:0] ai;
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            v[8*i +: 8] = ref_mem[ai[15:0]];
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
        logic [31:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            ref_mem[ai[15:0]] = wd[8*i +: 8];
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        ram[a[15:0]] <= v;
        ref_mem[a[15:0]] = v;
    endtask

    // A read of n bytes presents n addresses, holds the last one while the final byte returns, then acks.
    task automatic push_read(input logic [31:0] a, input int n, input bit mem_owner);
        for (int i = 0; i <= n; i++)
            exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, a + 32'((i < n) ? i : n - 1)));
        exp_q.push_back(ent(mem_owner, !mem_owner, 1'b1, 1'b0, 8'h00, 32'd0));
    endtask

    task automatic push_write(input logic [31:0] a, input int n, input logic [31:0] wd);
        for (int i = 0; i < n; i++)
            exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 1'b1, wd[8*i +: 8], a + 32'(i)));
        exp_q.push_back(ent(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'd0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input logic [31:0] exp_mdata, input bit chk_mdata,
                         input logic [31:0] exp_idata);
        logic [43:0] e;
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            k++;
            check_val($sformatf("%s_c%0d", tag, k), 64'(obs()), 64'(e));
            if (e[43]) begin
                if (chk_mdata) check_val({tag, "_mdata"}, 64'(mem_rdata_o), 64'(exp_mdata));
                mem_req_i = 1'b0;
            end
            if (e[42]) begin
                check_val({tag, "_idata"}, 64'(if_data_o), 64'(exp_idata));
                if_req_i = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        mem_req_i = 1'b0;
        if_req_i  = 1'b0;
        flush_i   = 1'b0;
        step();
        while (busy_o && t < 30) begin
            step();
            t++;
        end
        check_val({tag, "_idle"}, 64'(obs()), 64'd0);
    endtask

    task automatic episode(input string tag, input bit do_mem, input bit we, input logic [31:0] maddr,
                           input logic [1:0] len, input logic [31:0] wd, input bit do_if,
                           input logic [31:0] iaddr);
        logic [31:0] md;
        logic [31:0] id;
        md = 32'd0;
        id = 32'd0;
        if (do_mem) begin
            mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = maddr; mem_len_i = len; mem_wdata_i = wd;
            if (we) begin
                push_write(maddr, nbytes(len), wd);
                ref_store(maddr, nbytes(len), wd);
            end else begin
                md = ref_load(maddr, nbytes(len));
                push_read(maddr, nbytes(len), 1'b1);
            end
            if (do_if) exp_q.push_back(44'd0);
        end
        if (do_if) begin
            if_req_i = 1'b1; if_addr_i = iaddr;
            id = ref_load(iaddr, 4);
            push_read(iaddr, 4, 1'b0);
        end
        drain(tag, md, do_mem && !we, id);
        wait_idle(tag);
    endtask

    // Fetch killed by flush after f observed cycles, with a load waiting behind it.
    task automatic flush_episode(input string tag, input logic [31:0] iaddr, input int f,
                                 input logic [31:0] maddr, input logic [1:0] len);
        logic [31:0] md;
        if_req_i = 1'b1; if_addr_i = iaddr;
        for (int i = 0; i < f; i++)
            exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, iaddr + 32'((i < 4) ? i : 3)));
        drain(tag, 32'd0, 1'b0, 32'd0);
        flush_i = 1'b1; if_req_i = 1'b0;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = maddr; mem_len_i = len; mem_wdata_i = $urandom;
        step();
        check_val({tag, "_abort"}, 64'(obs()), 64'd0);
        flush_i = 1'b0;
        md = ref_load(maddr, nbytes(len));
        push_read(maddr, nbytes(len), 1'b1);
        drain({tag, "_ld"}, md, 1'b1, 32'd0);
        wait_idle(tag);
    endtask

    task automatic done_flush_episode(input string tag, input logic [31:0] iaddr);
        if_req_i = 1'b1; if_addr_i = iaddr;
        for (int i = 0; i <= 4; i++)
            exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, iaddr + 32'((i < 4) ? i : 3)));
        drain(tag, 32'd0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b1; if_req_i = 1'b0;
        #1;
        check_val({tag, "_noack"}, 64'(obs()), 64'(ent(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'd0)));
        flush_i = 1'b0;
        wait_idle(tag);
    endtask

    // Word store interrupted by reset after two bytes reached the RAM.
    task automatic reset_episode(input string tag, input logic [31:0] maddr, input logic [31:0] wd);
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = maddr; mem_len_i = 2'b10; mem_wdata_i = wd;
        for (int i = 0; i < 2; i++)
            exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 1'b1, wd[8*i +: 8], maddr + 32'(i)));
        drain(tag, 32'd0, 1'b0, 32'd0);
        rst = 1'b1; mem_req_i = 1'b0;
        step();
        check_val({tag, "_rst"}, 64'(obs()), 64'd0);
        rst = 1'b0;
        ref_store(maddr, 2, wd);
        wait_idle(tag);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 2))
            0:       return 32'h0000_1000 + 32'($urandom_range(0, 31));
            1:       return 32'hffff_fff0 + 32'($urandom_range(0, 31));
            default: return 32'h0000_2000 + 32'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        rst = 1'b1; if_req_i = 1'b0; if_addr_i = 32'd0; flush_i = 1'b0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'd0; mem_len_i = 2'b00; mem_wdata_i = 32'd0;
        for (int i = 0; i < 65536; i++) begin
            ram[i] <= init_byte(i);
            ref_mem[i] = init_byte(i);
        end
        repeat (3) step();
        check_val("reset_trace", 64'(obs()), 64'd0);
        check_val("reset_data", 64'({if_data_o, mem_rdata_o}), 64'd0);
        rst = 1'b0;
        step();

        poke(32'h1000, 8'h13); poke(32'h1001, 8'h05); poke(32'h1002, 8'h10); poke(32'h1003, 8'h00);
        poke(32'h0000_0003, 8'h80);
        episode("fetch_1000", 1'b0, 1'b0, 32'd0, 2'b00, 32'd0, 1'b1, 32'h1000);
        episode("both_st", 1'b1, 1'b1, 32'h2000, 2'b10, 32'hdeadbeef, 1'b1, 32'h1000);
        episode("lb_3", 1'b1, 1'b0, 32'h3, 2'b00, 32'd0, 1'b0, 32'd0);
        flush_episode("flush_c2", 32'h1000, 3, 32'h2000, 2'b10);
        reset_episode("rst_st", 32'h2004, 32'h11223344);
        episode("ld_2004", 1'b1, 1'b0, 32'h2004, 2'b11, 32'd0, 1'b0, 32'd0);
        episode("lh_wrap", 1'b1, 1'b0, 32'hffff_ffff, 2'b01, 32'd0, 1'b0, 32'd0);
        done_flush_episode("done_flush", 32'h1004);

        for (int it = 0; it < 200; it++) begin
            string tag;
            int kind;
            tag = $sformatf("r%0d", it);
            kind = $urandom_range(0, 19);
            if (kind < 7)
                episode(tag, 1'b1, 1'($urandom_range(0, 1)), pick_addr(), 2'($urandom_range(0, 3)),
                        $urandom, 1'b0, 32'd0);
            else if (kind < 10)
                episode(tag, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0, 1'b1, pick_addr());
            else if (kind < 15)
                episode(tag, 1'b1, 1'($urandom_range(0, 1)), pick_addr(), 2'($urandom_range(0, 3)),
                        $urandom, 1'b1, pick_addr());
            else if (kind < 17)
                flush_episode(tag, pick_addr(), $urandom_range(1, 5), pick_addr(), 2'($urandom_range(0, 3)));
            else if (kind < 19)
                done_flush_episode(tag, pick_addr());
            else
                reset_episode(tag, pick_addr(), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port if_req_i  input  1  fetch request; held high until if_ack_o.
REQ-004 SHALL have port if_addr_i  input  32  fetch byte address; stable while if_req_i is high.
REQ-005 SHALL have port if_ack_o  output  1  one-cycle fetch completion pulse.
REQ-006 SHALL have port if_data_o  output  32  fetched instruction word, valid with if_ack_o.
REQ-007 SHALL have port flush_i  input  1  branch-taken flush; cancels the fetch.
REQ-008 SHALL have port mem_req_i  input  1  load/store request; held high until mem_ack_o.
REQ-009 SHALL have port mem_we_i  input  1  1=store, 0=load.
REQ-010 SHALL have port mem_addr_i  input  32  data byte address; any alignment.
REQ-011 SHALL have port mem_len_i  input  2  00=byte, 01=half, 10/11=word.
REQ-012 SHALL have port mem_wdata_i  input  32  store data, little-endian, low bytes used.
REQ-013 SHALL have port mem_ack_o  output  1  one-cycle load/store completion pulse.
REQ-014 SHALL have port mem_rdata_o  output  32  load data, zero-filled above length; sign extension is outside this block.
REQ-015 SHALL have port ram_addr_o  output  32  byte address to single-port RAM.
REQ-016 SHALL have port ram_wr_o  output  1  RAM write strobe.
REQ-017 SHALL have port ram_dout_o  output  8  RAM write byte.
REQ-018 SHALL have port ram_din_i  input  8  RAM read byte, valid one cycle after its address.
REQ-019 SHALL have port busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-020 SHALL implement the FSM states IDLE, IF_RD, MEM_RD, MEM_WR and DONE, plus a 3-bit byte counter cnt.
REQ-021 In IDLE, SHALL grant the MEM port when mem_req_i=1, since MEM has fixed priority; otherwise SHALL grant IF when if_req_i=1 and flush_i=0; otherwise SHALL stay in IDLE.
REQ-022 SHALL latch the address, length, write data and grant owner at grant time and clear cnt; IF transfers always use length 4.
REQ-023 In read states, SHALL drive ram_addr_o = latched address + cnt (mod 2^32) while cnt < N, and hold the last address when cnt = N.
REQ-024 SHALL capture ram_din_i into byte cnt-1 of the read buffer when cnt >= 1, and SHALL go to DONE after the capture at cnt = N.
REQ-025 In MEM_WR, SHALL drive ram_wr_o=1, ram_addr_o = address + cnt and ram_dout_o = wdata byte cnt for cnt = 0..N-1, then go to DONE.
REQ-026 In DONE, SHALL assert the owner's ack for exactly one cycle with data, then return to IDLE; no grant is made in the DONE cycle.
REQ-027 Latency from a request sampled in IDLE to ack SHALL be N+2 cycles for reads and N+1 cycles for writes.
REQ-028 flush_i=1 during IF_RD SHALL abort the fetch: next state IDLE, no if_ack_o.
REQ-029 flush_i=1 during DONE with owner IF SHALL suppress if_ack_o.
REQ-030 flush_i SHALL never affect a MEM transaction.
REQ-031 Outside MEM_WR, ram_wr_o SHALL be 0; in IDLE and DONE, ram_addr_o and ram_dout_o SHALL be 0.
REQ-032 An unserved request SHALL wait indefinitely; IF starvation under continuous MEM traffic is accepted.

Reset
REQ-033 On rst=1 at a clock edge, SHALL enter IDLE and clear cnt and the buffers, with all outputs 0 the next cycle.
REQ-034 Reset mid-transfer SHALL abort with no ack and no further RAM write.

Verification
REQ-035 IF fetch at 0x1000, RAM bytes 13 05 10 00 -> ram_addr_o 0x1000..0x1003 on cycles 0..3; if_ack_o on cycle 5; if_data_o=0x00100513.
REQ-036 Simultaneous if_req_i and mem_req_i (store word 0xDEADBEEF at 0x2000) -> writes EF,BE,AD,DE to 0x2000..0x2003; mem_ack_o; IF granted in the next IDLE.
REQ-037 LB at 0x3 with byte 0x80 -> mem_ack_o 3 cycles after grant; mem_rdata_o=0x00000080.
REQ-038 flush_i on cycle 2 of a fetch -> no if_ack_o; IDLE next cycle; a pending mem_req_i is then granted.
REQ-039 rst after 2 bytes of a word store -> ram_wr_o=0 the next cycle; no mem_ack_o; busy_o=0.
REQ-040 Halfword load at 0xFFFFFFFF -> ram_addr_o 0xFFFFFFFF then 0x00000000; data assembled little-endian.
